rsa_modexp_seq: RTL and testbench

//  Sequencer for left-to-right square-and-multiply modular exponentiation.
//  - Starts the bit-length unit on the latched exponent, then walks exponent bits MSB->LSB.
//  - Issues square/multiply commands to the shared modular multiplier via start/done handshakes.
//  - Sits between the RSA top-level control and the bit-length and multiplier datapaths.

---
 rtl/rsa_modexp_seq.sv | 168 ++++++++++++++++
 tb/tb_rsa_modexp_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_seq.sv
// rsa_modexp_seq
//   Sequencer for left-to-right square-and-multiply modular exponentiation.
//   It latches the exponent and starts the bit-length unit. The MSB seeds the
//   accumulator. Each lower bit then costs one square plus, when the bit is
//   set, one multiply by the base. Every multiplier operation is a
//   start/done handshake.
//
//   Build option: RSA_MODEXP_DUMMY_MUL_EN
//     defined   - a 0 bit also issues a multiply that is flagged dummy, so the
//                 operation sequence does not depend on the exponent bits.
//     undefined - no dummy operations; oMulDummy is tied low.
//
// Ports
//   iClk, iRstn          clock (rising edge), synchronous active-low reset
//   iStart, iExp         start request and exponent (sampled in IDLE only)
//   oBusy, oDone         busy flag, 1-cycle completion pulse
//   oNbStart, oNbData    bit-length unit start pulse and latched exponent
//   iNbDone, iNbBits     bit-length result pulse and used-bit count N
//   oInitOne, oInitBase  accumulator init pulses (N==0 / N>=1)
//   oMulStart, oMulOp    multiplier launch pulse, 0=square 1=multiply
//   oMulDummy            result of this operation must be discarded
//   iMulDone             multiplier completion pulse
module rsa_modexp_seq #(
   parameter int DATA_W = 1024,
   parameter int CNT_W  = 11
) (
   input  logic              iClk,
   input  logic              iRstn,
   input  logic              iStart,
   input  logic [DATA_W-1:0] iExp,
   output logic              oBusy,
   output logic              oDone,
   output logic              oNbStart,
   output logic [DATA_W-1:0] oNbData,
   input  logic              iNbDone,
   input  logic [CNT_W-1:0]  iNbBits,
   output logic              oInitOne,
   output logic              oInitBase,
   output logic              oMulStart,
   output logic              oMulOp,
   output logic              oMulDummy,
   input  logic              iMulDone
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] N_MAX = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      IDLE, NBIT, INIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, DONE
   } state_t;

   state_t              state, state_d;
   logic [DATA_W-1:0]   exp_reg, exp_d;
   logic [CNT_W-1:0]    idx, idx_d;
   logic [CNT_W-1:0]    n_bits, n_d;
   logic [CNT_W-1:0]    n_clamp;
   logic                exp_bit;
`ifdef RSA_MODEXP_DUMMY_MUL_EN
   logic                dummy_d;
`endif

   // The bit-length unit may report more bits than the exponent holds.
   assign n_clamp = (iNbBits > N_MAX) ? N_MAX : iNbBits;
   // idx never exceeds DATA_W-1, so the low bits are enough to index.
   assign exp_bit = exp_reg[idx[IDX_W-1:0]];
   assign oNbData = exp_reg;

   always_comb begin
      state_d = state;
      exp_d   = exp_reg;
      idx_d   = idx;
      n_d     = n_bits;
`ifdef RSA_MODEXP_DUMMY_MUL_EN
      dummy_d = 1'b0;
`endif
      case (state)
         IDLE: if (iStart) begin
            exp_d   = iExp;
            state_d = NBIT;
         end
         NBIT: if (iNbDone) begin
            n_d     = n_clamp;
            state_d = INIT;
         end
         INIT: begin
            // The init consumes the MSB. Squaring starts at bit N-2.
            if (n_bits == '0) begin
               state_d = DONE;
            end else if (n_bits == CNT_W'(1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d   = n_bits - CNT_W'(2);
               state_d = SQ_REQ;
            end
         end
         SQ_REQ:  state_d = SQ_WAIT;
         SQ_WAIT: if (iMulDone) begin
            if (exp_bit) begin
               state_d = MUL_REQ;
`ifdef RSA_MODEXP_DUMMY_MUL_EN
            end else begin
               state_d = MUL_REQ;
               dummy_d = 1'b1;
            end
`else
            end else if (idx == '0) begin
               state_d = DONE;
            end else begin
               idx_d   = idx - CNT_W'(1);
               state_d = SQ_REQ;
            end
`endif
         end
         MUL_REQ:  state_d = MUL_WAIT;
         MUL_WAIT: if (iMulDone) begin
            if (idx == '0) begin
               state_d = DONE;
            end else begin
               idx_d   = idx - CNT_W'(1);
               state_d = SQ_REQ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state, so each output lines up
   // with the state cycle it describes.
   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state     <= IDLE;
         exp_reg   <= '0;
         idx       <= '0;
         n_bits    <= '0;
         oBusy     <= 1'b0;
         oDone     <= 1'b0;
         oNbStart  <= 1'b0;
         oInitOne  <= 1'b0;
         oInitBase <= 1'b0;
         oMulStart <= 1'b0;
         oMulOp    <= 1'b0;
      end else begin
         state     <= state_d;
         exp_reg   <= exp_d;
         idx       <= idx_d;
         n_bits    <= n_d;
         oBusy     <= (state_d != IDLE);
         oDone     <= (state_d == DONE);
         oNbStart  <= (state_d == NBIT) && (state != NBIT);
         oInitOne  <= (state_d == INIT) && (n_d == '0);
         oInitBase <= (state_d == INIT) && (n_d != '0);
         oMulStart <= (state_d == SQ_REQ) || (state_d == MUL_REQ);
         oMulOp    <= (state_d == MUL_REQ);
      end
   end

`ifdef RSA_MODEXP_DUMMY_MUL_EN
   always_ff @(posedge iClk) begin
      if (!iRstn) oMulDummy <= 1'b0;
      else        oMulDummy <= (state_d == MUL_REQ) && dummy_d;
   end
`else
   assign oMulDummy = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// tb_rsa_modexp_seq
//   Directed bench for rsa_modexp_seq. Each stimulus pushes the expected
//   event stream into a queue. A monitor pops and compares whenever the DUT
//   raises an init, multiplier-start or done pulse. The bench also acts as
//   the bit-length unit and the multiplier, with programmable latencies.
module tb_rsa_modexp_seq;
   localparam int DW = 1024;
   localparam int CW = 11;

   localparam int EV_ONE  = 0;
   localparam int EV_BASE = 1;
   localparam int EV_SQ   = 2;
   localparam int EV_MUL  = 3;
   localparam int EV_DMY  = 4;
   localparam int EV_DONE = 5;
   localparam int EV_BAD  = 6;

   logic          iClk = 1'b0;
   logic          iRstn;
   logic          iStart;
   logic [DW-1:0] iExp;
   logic          oBusy, oDone, oNbStart;
   logic [DW-1:0] oNbData;
   logic          iNbDone;
   logic [CW-1:0] iNbBits;
   logic          oInitOne, oInitBase, oMulStart, oMulOp, oMulDummy;
   logic          iMulDone;

   int            checks = 0;
   int            errors = 0;
   int            exp_q[$];
   int            mul_starts = 0;
   int            mul_delay = 1;
   int            nb_delay = 1;
   logic [CW-1:0] nb_bits_val = '0;
   logic [DW-1:0] cur_exp = '0;
   bit            outstanding = 1'b0;

   rsa_modexp_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
      .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iExp(iExp),
      .oBusy(oBusy), .oDone(oDone), .oNbStart(oNbStart), .oNbData(oNbData),
      .iNbDone(iNbDone), .iNbBits(iNbBits), .oInitOne(oInitOne),
      .oInitBase(oInitBase), .oMulStart(oMulStart), .oMulOp(oMulOp),
      .oMulDummy(oMulDummy), .iMulDone(iMulDone)
   );

   always #5 iClk = ~iClk;

   // Expected event stream for left-to-right square-and-multiply.
   task automatic push_model(input logic [DW-1:0] e, input int n);
      if (n == 0) begin
         exp_q.push_back(EV_ONE);
      end else begin
         exp_q.push_back(EV_BASE);
         for (int i = n - 2; i >= 0; i--) begin
            exp_q.push_back(EV_SQ);
            if (e[i]) exp_q.push_back(EV_MUL);
`ifdef RSA_MODEXP_DUMMY_MUL_EN
            else      exp_q.push_back(EV_DMY);
`endif
         end
      end
      exp_q.push_back(EV_DONE);
   endtask

   task automatic sb(input string name, input int got);
      int want;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event %0d, queue empty", name, got);
      end else begin
         want = exp_q.pop_front();
         if (got != want) begin
            errors++;
            $display("FAIL %s: got event %0d, expected %0d", name, got, want);
         end
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({oBusy, oDone, oNbStart, oInitOne, oInitBase, oMulStart, oMulOp,
           oMulDummy} !== 8'h00 || oNbData !== '0) begin
         errors++;
         $display("FAIL %s: outputs b%b d%b nb%b one%b base%b ms%b op%b dm%b data_lo=%h, all must be 0",
                  name, oBusy, oDone, oNbStart, oInitOne, oInitBase, oMulStart,
                  oMulOp, oMulDummy, oNbData[63:0]);
      end
   endtask

   // Bit-length unit model.
   initial begin : nb_resp
      iNbDone = 1'b0;
      iNbBits = '0;
      forever begin
         @(negedge iClk);
         iNbDone = 1'b0;
         if (oNbStart && iRstn) begin
            repeat (nb_delay) @(negedge iClk);
            iNbBits = nb_bits_val;
            iNbDone = 1'b1;
         end
      end
   end

   // Multiplier model: done arrives mul_delay cycles after the start cycle.
   initial begin : mul_resp
      iMulDone = 1'b0;
      forever begin
         @(negedge iClk);
         iMulDone = 1'b0;
         if (oMulStart && iRstn) begin
            repeat (mul_delay) @(negedge iClk);
            iMulDone = 1'b1;
         end
      end
   end

   // Monitor: samples just after the rising edge.
   initial begin : mon
      int ev;
      forever begin
         @(posedge iClk);
         #1;
         if (!iRstn) begin
            outstanding = 1'b0;
            continue;
         end
         if (iMulDone) outstanding = 1'b0;
         if (oNbStart) begin
            checks++;
            if (oNbData !== cur_exp) begin
               errors++;
               $display("FAIL nb_data: got lo=%h, expected lo=%h",
                        oNbData[63:0], cur_exp[63:0]);
            end
         end
         if (oInitOne)  sb("init_one", EV_ONE);
         if (oInitBase) sb("init_base", EV_BASE);
         if (oMulStart) begin
            mul_starts++;
            checks++;
            if (outstanding) begin
               errors++;
               $display("FAIL mul_handshake: start issued with op outstanding=%0d, expected 0",
                        outstanding);
            end
            outstanding = 1'b1;
            ev = oMulOp ? (oMulDummy ? EV_DMY : EV_MUL) : (oMulDummy ? EV_BAD : EV_SQ);
            sb("mul_op", ev);
         end
         if (oDone) sb("done", EV_DONE);
      end
   end

   task automatic run(input string name, input logic [DW-1:0] e, input int nb,
                      input int md, input int nd, input int want_starts,
                      input bit poke);
      int  n;
      bit  got_done;
      bit  poked;
      n           = (nb > DW) ? DW : nb;
      cur_exp     = e;
      nb_bits_val = CW'(nb);
      mul_delay   = md;
      nb_delay    = nd;
      mul_starts  = 0;
      push_model(e, n);
      @(negedge iClk);
      iStart = 1'b1;
      iExp   = e;
      @(negedge iClk);
      iStart = 1'b0;
      iExp   = {32{$urandom}};
      checks++;
      if (oBusy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start: got %b, expected 1", name, oBusy);
      end
      got_done = 1'b0;
      poked    = 1'b0;
      for (int c = 0; c < 20000 && !got_done; c++) begin
         @(negedge iClk);
         if (oDone) begin
            got_done = 1'b1;
         end else if (poke && !poked && oMulStart) begin
            // Next cycle is SQ_WAIT: a start there must be ignored.
            @(negedge iClk);
            iStart = 1'b1;
            iExp   = ~e;
            @(negedge iClk);
            iStart = 1'b0;
            poked  = 1'b1;
         end
      end
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL %s timeout: no oDone within budget, got %0d starts", name, mul_starts);
      end
      @(negedge iClk);
      checks++;
      if (oBusy !== 1'b0 || oDone !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after_done: busy=%b done=%b, expected 0 0", name, oBusy, oDone);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s queue: %0d expected events never seen, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (mul_starts != want_starts) begin
         errors++;
         $display("FAIL %s op_count: got %0d starts, expected %0d", name, mul_starts, want_starts);
      end
      checks++;
      if (oNbData !== e) begin
         errors++;
         $display("FAIL %s exp_hold: got lo=%h, expected lo=%h", name, oNbData[63:0], e[63:0]);
      end
   endtask

   initial begin : main
      logic [DW-1:0] big;
      bit            hit;
      big         = '0;
      big[DW-1]   = 1'b1;
      big[0]      = 1'b1;
      iRstn       = 1'b0;
      iStart      = 1'b0;
      iExp        = '0;
      repeat (3) @(negedge iClk);
      check_idle("reset_state");
      iRstn = 1'b1;

`ifdef RSA_MODEXP_DUMMY_MUL_EN
      run("exp0",     DW'(0),     0,    1, 2, 0,    0);
      run("exp1",     DW'(1),     1,    1, 1, 0,    0);
      run("exp11",    DW'(11),    4,    1, 1, 6,    0);
      run("f4_d1",    DW'(65537), 17,   1, 1, 32,   0);
      run("f4_d7",    DW'(65537), 17,   7, 3, 32,   0);
      run("big",      big,        1024, 1, 1, 2046, 0);
      run("clamp",    big,        2047, 1, 1, 2046, 0);
      run("ign_start", DW'(11),   4,    5, 1, 6,    1);
`else
      run("exp0",     DW'(0),     0,    1, 2, 0,    0);
      run("exp1",     DW'(1),     1,    1, 1, 0,    0);
      run("exp11",    DW'(11),    4,    1, 1, 5,    0);
      run("f4_d1",    DW'(65537), 17,   1, 1, 17,   0);
      run("f4_d7",    DW'(65537), 17,   7, 3, 17,   0);
      run("big",      big,        1024, 1, 1, 1024, 0);
      run("clamp",    big,        2047, 1, 1, 1024, 0);
      run("ign_start", DW'(11),   4,    5, 1, 5,    1);
`endif

      // Reset while a multiply is in flight.
      cur_exp     = DW'(11);
      nb_bits_val = CW'(4);
      mul_delay   = 3;
      nb_delay    = 1;
      push_model(DW'(11), 4);
      @(negedge iClk);
      iStart = 1'b1;
      iExp   = DW'(11);
      @(negedge iClk);
      iStart = 1'b0;
      hit    = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge iClk);
         if (oMulStart && oMulOp) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL rst_mid reach_mul: multiply start seen=%b, expected 1", hit);
      end
      @(negedge iClk);
      iRstn = 1'b0;
      @(negedge iClk);
      check_idle("reset_mid_op");
      repeat (6) @(negedge iClk);
      exp_q.delete();
      iRstn = 1'b1;
`ifdef RSA_MODEXP_DUMMY_MUL_EN
      run("after_rst", DW'(11), 4, 2, 1, 6, 0);
`else
      run("after_rst", DW'(11), 4, 2, 1, 5, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
